pipe_id: RTL and testbench

- Instruction-decode stage of the 5-stage MIPS-subset pipeline.
- Consumes the IF/ID outputs (registered instruction and PC+4).
- Holds the 32x32 register file; performs decode, operand forwarding, load-use stall detection, and branch/jump resolution.
- Registers the decoded control and operands into the ID/EX pipeline register for the EX stage.

---
 rtl/pipe_id.sv | 154 +++++++++++++++
 tb/tb_pipe_id.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_id.sv
// Decode stage: register file, operand forwarding, load-use stall, branch/jump resolve, ID/EX register.
// Next-PC controls and wpcir are same-cycle; e_* outputs one cycle later; wpcir low holds PC and IF/ID.
module pipe_id (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] inst,
    input  logic [31:0] p4,
    input  logic        wb_we,
    input  logic [4:0]  wb_rn,
    input  logic [31:0] wb_data,
    input  logic        ex_wreg,
    input  logic        ex_m2reg,
    input  logic [4:0]  ex_rn,
    input  logic [31:0] ex_alu,
    input  logic        mem_wreg,
    input  logic        mem_m2reg,
    input  logic [4:0]  mem_rn,
    input  logic [31:0] mem_alu,
    input  logic [31:0] mem_mdata,
    output logic        wpcir,
    output logic [1:0]  pcsrc,
    output logic [31:0] bpc,
    output logic [31:0] jpc,
    output logic        e_wreg,
    output logic        e_m2reg,
    output logic        e_wmem,
    output logic        e_aluimm,
    output logic [2:0]  e_aluc,
    output logic [31:0] e_a,
    output logic [31:0] e_b,
    output logic [31:0] e_imm,
    output logic [4:0]  e_rn
);
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sx;

    assign op     = inst[31:26];
    assign rs     = inst[25:21];
    assign rt     = inst[20:16];
    assign rd     = inst[15:11];
    assign funct  = inst[5:0];
    assign imm_sx = {{16{inst[15]}}, inst[15:0]};

    logic r_add, r_sub, r_and, r_or, r_slt, i_rtype;
    logic i_addi, i_lw, i_sw, i_beq, i_bne, i_j;

    assign r_add   = (op == 6'b000000) && (funct == 6'b100000);
    assign r_sub   = (op == 6'b000000) && (funct == 6'b100010);
    assign r_and   = (op == 6'b000000) && (funct == 6'b100100);
    assign r_or    = (op == 6'b000000) && (funct == 6'b100101);
    assign r_slt   = (op == 6'b000000) && (funct == 6'b101010);
    assign i_rtype = r_add | r_sub | r_and | r_or | r_slt;
    assign i_addi  = (op == 6'b001000);
    assign i_lw    = (op == 6'b100011);
    assign i_sw    = (op == 6'b101011);
    assign i_beq   = (op == 6'b000100);
    assign i_bne   = (op == 6'b000101);
    assign i_j     = (op == 6'b000010);

    logic [2:0] aluc;
    logic [4:0] dest;
    logic       wreg;
    logic       use_rs;
    logic       use_rt;
    logic       stall;

    always_comb begin
        aluc = 3'b000;
        if (r_sub) aluc = 3'b001;
        if (r_and) aluc = 3'b010;
        if (r_or)  aluc = 3'b011;
        if (r_slt) aluc = 3'b100;
    end

    assign dest   = (i_addi | i_lw) ? rt : rd;
    assign wreg   = (i_rtype | i_addi | i_lw) && (dest != 5'd0);
    assign use_rs = i_rtype | i_addi | i_lw | i_sw | i_beq | i_bne;
    assign use_rt = i_rtype | i_sw | i_beq | i_bne;
    // Only a load in EX can't be forwarded; its data arrives a cycle too late.
    assign stall  = ex_wreg && ex_m2reg && (ex_rn != 5'd0) &&
                    ((use_rs && (ex_rn == rs)) || (use_rt && (ex_rn == rt)));
    assign wpcir  = ~stall;

    logic [31:0] regs [0:31];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_we && (wb_rn != 5'd0)) begin
            regs[wb_rn] <= wb_data;
        end
    end

    logic [31:0] rf_a;
    logic [31:0] rf_b;
    logic [31:0] fa;
    logic [31:0] fb;

    assign rf_a = (rs == 5'd0) ? '0 : (wb_we && (wb_rn == rs)) ? wb_data : regs[rs];
    assign rf_b = (rt == 5'd0) ? '0 : (wb_we && (wb_rn == rt)) ? wb_data : regs[rt];

    function automatic logic [31:0] fwd(input logic [4:0] n, input logic [31:0] rf_val);
        if ((n != 5'd0) && ex_wreg && !ex_m2reg && (ex_rn == n))
            return ex_alu;
        else if ((n != 5'd0) && mem_wreg && (mem_rn == n))
            return mem_m2reg ? mem_mdata : mem_alu;
        else
            return rf_val;
    endfunction

    assign fa = fwd(rs, rf_a);
    assign fb = fwd(rt, rf_b);

    assign bpc = p4 + {imm_sx[29:0], 2'b00};
    assign jpc = {p4[31:28], inst[25:0], 2'b00};

    always_comb begin
        pcsrc = 2'b00;
        if (!stall) begin
            if (i_j)
                pcsrc = 2'b10;
            else if ((i_beq && (fa == fb)) || (i_bne && (fa != fb)))
                pcsrc = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            e_wreg   <= 1'b0;
            e_m2reg  <= 1'b0;
            e_wmem   <= 1'b0;
            e_aluimm <= 1'b0;
            e_aluc   <= 3'b000;
            e_a      <= '0;
            e_b      <= '0;
            e_imm    <= '0;
            e_rn     <= '0;
        end else begin
            e_wreg   <= wreg & ~stall;
            e_m2reg  <= i_lw & ~stall;
            e_wmem   <= i_sw & ~stall;
            e_aluimm <= i_addi | i_lw | i_sw;
            e_aluc   <= aluc;
            e_a      <= fa;
            e_b      <= fb;
            e_imm    <= imm_sx;
            e_rn     <= dest;
        end
    end
endmodule

// File: tb/tb_pipe_id.sv
// Randomized and directed bench for pipe_id against an instruction-level reference model.
module tb_pipe_id;
    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] inst, p4, wb_data, ex_alu, mem_alu, mem_mdata;
    logic        wb_we, ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
    logic [4:0]  wb_rn, ex_rn, mem_rn;
    logic        wpcir;
    logic [1:0]  pcsrc;
    logic [31:0] bpc, jpc, e_a, e_b, e_imm;
    logic        e_wreg, e_m2reg, e_wmem, e_aluimm;
    logic [2:0]  e_aluc;
    logic [4:0]  e_rn;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [5:0] OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

    pipe_id dut (
        .clk(clk), .clrn(clrn), .inst(inst), .p4(p4),
        .wb_we(wb_we), .wb_rn(wb_rn), .wb_data(wb_data),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn), .ex_alu(ex_alu),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
        .mem_alu(mem_alu), .mem_mdata(mem_mdata),
        .wpcir(wpcir), .pcsrc(pcsrc), .bpc(bpc), .jpc(jpc),
        .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem), .e_aluimm(e_aluimm),
        .e_aluc(e_aluc), .e_a(e_a), .e_b(e_b), .e_imm(e_imm), .e_rn(e_rn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] f, input int s, input int t, input int d);
        logic [4:0] s5 = 5'(s);
        logic [4:0] t5 = 5'(t);
        logic [4:0] d5 = 5'(d);
        return {6'b000000, s5, t5, d5, 5'b00000, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] o, input int s, input int t, input logic [15:0] im);
        logic [4:0] s5 = 5'(s);
        logic [4:0] t5 = 5'(t);
        return {o, s5, t5, im};
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       valid, wreg, m2reg, wmem, aluimm;
        logic [2:0] aluc;
        logic [4:0] rn;
        logic       use_rs, use_rt, beq, bne, j;
    } dec_t;

    logic [31:0] rf [32];

    function automatic dec_t decode(input logic [31:0] w);
        dec_t d = '0;
        case (w[31:26])
            6'b000000: begin
                case (w[5:0])
                    F_ADD: begin d.valid = 1; d.aluc = 3'd0; end
                    F_SUB: begin d.valid = 1; d.aluc = 3'd1; end
                    F_AND: begin d.valid = 1; d.aluc = 3'd2; end
                    F_OR:  begin d.valid = 1; d.aluc = 3'd3; end
                    F_SLT: begin d.valid = 1; d.aluc = 3'd4; end
                    default: ;
                endcase
                if (d.valid) begin
                    d.rn = w[15:11]; d.wreg = 1; d.use_rs = 1; d.use_rt = 1;
                end
            end
            OP_ADDI: begin d.valid = 1; d.aluimm = 1; d.rn = w[20:16]; d.wreg = 1; d.use_rs = 1; end
            OP_LW:   begin d.valid = 1; d.aluimm = 1; d.rn = w[20:16]; d.wreg = 1; d.m2reg = 1; d.use_rs = 1; end
            OP_SW:   begin d.valid = 1; d.aluimm = 1; d.wmem = 1; d.use_rs = 1; d.use_rt = 1; end
            OP_BEQ:  begin d.valid = 1; d.beq = 1; d.use_rs = 1; d.use_rt = 1; end
            OP_BNE:  begin d.valid = 1; d.bne = 1; d.use_rs = 1; d.use_rt = 1; end
            6'b000010: begin d.valid = 1; d.j = 1; end
            default: ;
        endcase
        if (d.rn == 5'd0) d.wreg = 0;
        return d;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] n);
        if (n == 5'd0) return 32'd0;
        if (ex_wreg && !ex_m2reg && ex_rn == n) return ex_alu;
        if (mem_wreg && mem_rn == n) return mem_m2reg ? mem_mdata : mem_alu;
        if (wb_we && wb_rn == n) return wb_data;
        return rf[n];
    endfunction

    logic        p_wreg, p_m2reg, p_wmem, p_aluimm;
    logic [2:0]  p_aluc;
    logic [31:0] p_a, p_b, p_imm;
    logic [4:0]  p_rn;
    logic        ck_a, ck_b, ck_imm, ck_rn;

    // Single compare process on the falling edge: registered outputs against last
    // cycle's prediction, then same-cycle outputs, then the next prediction.
    always @(negedge clk) begin
        dec_t        d;
        logic [31:0] a, b, exp_bpc;
        logic        st;
        logic [1:0]  exp_pc;
        int          off;
        if (!clrn) begin
            for (int i = 0; i < 32; i++) rf[i] = 32'd0;
            {p_wreg, p_m2reg, p_wmem, p_aluimm, p_aluc, p_a, p_b, p_imm, p_rn} = '0;
            {ck_a, ck_b, ck_imm, ck_rn} = 4'b1111;
        end
        chk("e_wreg", 32'(e_wreg), 32'(p_wreg));
        chk("e_m2reg", 32'(e_m2reg), 32'(p_m2reg));
        chk("e_wmem", 32'(e_wmem), 32'(p_wmem));
        chk("e_aluimm", 32'(e_aluimm), 32'(p_aluimm));
        chk("e_aluc", 32'(e_aluc), 32'(p_aluc));
        if (ck_a)   chk("e_a", e_a, p_a);
        if (ck_b)   chk("e_b", e_b, p_b);
        if (ck_imm) chk("e_imm", e_imm, p_imm);
        if (ck_rn)  chk("e_rn", 32'(e_rn), 32'(p_rn));

        d  = decode(inst);
        a  = operand(inst[25:21]);
        b  = operand(inst[20:16]);
        st = ex_wreg && ex_m2reg && ex_rn != 0 &&
             ((d.use_rs && ex_rn == inst[25:21]) || (d.use_rt && ex_rn == inst[20:16]));
        if (st) exp_pc = 2'd0;
        else if (d.j) exp_pc = 2'd2;
        else if ((d.beq && a == b) || (d.bne && a != b)) exp_pc = 2'd1;
        else exp_pc = 2'd0;
        off = $signed(inst[15:0]);
        exp_bpc = p4 + 32'(off * 4);
        chk("wpcir", 32'(wpcir), 32'(!st));
        chk("pcsrc", 32'(pcsrc), 32'(exp_pc));
        chk("bpc", bpc, exp_bpc);
        chk("jpc", jpc, {p4[31:28], inst[25:0], 2'b00});

        if (clrn) begin
            p_wreg   = d.wreg && !st;
            p_m2reg  = d.m2reg && !st;
            p_wmem   = d.wmem && !st;
            p_aluimm = d.aluimm;
            p_aluc   = d.aluc;
            p_a      = a;
            p_b      = b;
            p_imm    = 32'(off);
            p_rn     = d.rn;
            ck_a     = d.use_rs;
            ck_b     = d.use_rt;
            ck_imm   = d.aluimm;
            ck_rn    = d.wreg;
            if (wb_we && wb_rn != 0) rf[wb_rn] = wb_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst = 32'd0; p4 = 32'd0;
        wb_we = 0; wb_rn = 0; wb_data = 0;
        ex_wreg = 0; ex_m2reg = 0; ex_rn = 0; ex_alu = 0;
        mem_wreg = 0; mem_m2reg = 0; mem_rn = 0; mem_alu = 0; mem_mdata = 0;
    endtask

    initial begin
        clear_inputs();
        clrn = 0;
        repeat (2) tick();
        clrn = 1;

        // reset and basic addi
        wb_we = 1; wb_rn = 3; wb_data = 32'd5; tick();
        wb_we = 0; inst = itype(OP_ADDI, 3, 4, 16'd7); tick();
        chk("addi_e_a", e_a, 32'd5);
        chk("addi_e_imm", e_imm, 32'd7);
        chk("addi_e_aluimm", 32'(e_aluimm), 32'd1);
        chk("addi_e_aluc", 32'(e_aluc), 32'd0);
        chk("addi_e_rn", 32'(e_rn), 32'd4);
        chk("addi_e_wreg", 32'(e_wreg), 32'd1);
        clrn = 0; #1;
        chk("rst_e_ctl", {28'd0, e_wreg, e_m2reg, e_wmem, e_aluimm}, 32'd0);
        chk("rst_e_a", e_a, 32'd0);
        chk("rst_e_imm", e_imm, 32'd0);
        chk("rst_e_rn", 32'(e_rn), 32'd0);
        tick();
        clrn = 1; tick();
        chk("rst_r3_cleared", e_a, 32'd0);

        // forwarding priority
        inst = itype(OP_ADDI, 2, 9, 16'd0);
        ex_wreg = 1; ex_rn = 2; ex_alu = 32'h11;
        mem_wreg = 1; mem_rn = 2; mem_alu = 32'h22; mem_mdata = 32'h33;
        tick(); chk("fwd_ex", e_a, 32'h11);
        ex_wreg = 0; tick(); chk("fwd_mem_alu", e_a, 32'h22);
        mem_m2reg = 1; tick(); chk("fwd_mem_load", e_a, 32'h33);
        clear_inputs();

        // load-use stall
        ex_wreg = 1; ex_m2reg = 1; ex_rn = 5;
        inst = rtype(F_ADD, 5, 1, 6); #1;
        chk("lu_wpcir", 32'(wpcir), 32'd0);
        tick();
        chk("lu_bubble", {29'd0, e_wreg, e_m2reg, e_wmem}, 32'd0);
        inst = {6'b000010, 26'h0000123}; #1;
        chk("lu_j_wpcir", 32'(wpcir), 32'd1);
        chk("lu_j_pcsrc", 32'(pcsrc), 32'd2);
        clear_inputs();

        // branches
        wb_we = 1; wb_rn = 1; wb_data = 32'd9; tick();
        wb_rn = 2; tick();
        wb_we = 0; p4 = 32'h100; inst = itype(OP_BEQ, 1, 2, 16'hFFFE); #1;
        chk("beq_taken", 32'(pcsrc), 32'd1);
        chk("beq_bpc", bpc, 32'h0F8);
        wb_we = 1; wb_rn = 2; wb_data = 32'd8; tick();
        wb_we = 0; #1;
        chk("beq_not_taken", 32'(pcsrc), 32'd0);
        inst = itype(OP_BNE, 1, 2, 16'hFFFE); #1;
        chk("bne_taken", 32'(pcsrc), 32'd1);
        clear_inputs();

        // r0 handling
        inst = itype(OP_ADDI, 0, 0, 16'd1); tick();
        chk("r0_no_wreg", 32'(e_wreg), 32'd0);
        wb_we = 1; wb_rn = 0; wb_data = 32'hFF;
        ex_wreg = 1; ex_m2reg = 1; ex_rn = 0;
        inst = rtype(F_ADD, 0, 0, 8); #1;
        chk("r0_no_stall", 32'(wpcir), 32'd1);
        tick(); chk("r0_wt", e_a, 32'd0);
        wb_we = 0; tick(); chk("r0_read", e_a, 32'd0);
        clear_inputs();

        // write-through on store data
        wb_we = 1; wb_rn = 7; wb_data = 32'hAB;
        inst = itype(OP_SW, 1, 7, 16'd4); tick();
        chk("wt_e_b", e_b, 32'hAB);
        chk("wt_e_wmem", 32'(e_wmem), 32'd1);
        chk("wt_e_wreg", 32'(e_wreg), 32'd0);
        clear_inputs();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int k, s, t, d;
            k = $urandom_range(0, 11);
            s = $urandom_range(0, 7);
            t = $urandom_range(0, 7);
            d = $urandom_range(0, 7);
            if ((k == 8 || k == 9) && $urandom_range(0, 1) == 1) t = s;
            case (k)
                0: inst = rtype(F_ADD, s, t, d);
                1: inst = rtype(F_SUB, s, t, d);
                2: inst = rtype(F_AND, s, t, d);
                3: inst = rtype(F_OR, s, t, d);
                4: inst = rtype(F_SLT, s, t, d);
                5: inst = itype(OP_ADDI, s, t, 16'($urandom));
                6: inst = itype(OP_LW, s, t, 16'($urandom));
                7: inst = itype(OP_SW, s, t, 16'($urandom));
                8: inst = itype(OP_BEQ, s, t, 16'($urandom));
                9: inst = itype(OP_BNE, s, t, 16'($urandom));
                10: inst = {6'b000010, 26'($urandom)};
                default: inst = $urandom;
            endcase
            if (k < 5) inst[10:6] = 5'($urandom);
            p4        = {$urandom, 2'b00} >> 0;
            p4[1:0]   = 2'b00;
            wb_we     = 1'($urandom);
            wb_rn     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            ex_wreg   = 1'($urandom);
            ex_m2reg  = ($urandom_range(0, 3) == 0);
            ex_rn     = 5'($urandom_range(0, 7));
            ex_alu    = $urandom;
            mem_wreg  = 1'($urandom);
            mem_m2reg = 1'($urandom);
            mem_rn    = 5'($urandom_range(0, 7));
            mem_alu   = $urandom;
            mem_mdata = $urandom;
            clrn      = ($urandom_range(0, 149) != 0);
            tick();
        end
        clrn = 1;
        clear_inputs();
        tick();
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
